cube_root_ctrl: RTL and testbench

- Sequencer directly upstream of the cube-root datapath.
- Accepts a 32-bit operand with a start/done handshake and latches it onto the datapath `in` bus.
- Drives `clear`, `iter` (10 down to 0) and the trial `factor` = 12*y^2 + 6*y + 1, where y is the partial root fed back from the datapath `res`.
- Captures the final 11-bit floor cube root and reports completion.

---
 rtl/cube_root_ctrl.sv | 63 ++++++
 tb/tb_cube_root_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cube_root_ctrl.sv
// cube_root_ctrl: sequencer that drives a digit-serial cube-root datapath and captures the root
module cube_root_ctrl #(
  parameter int ITERS = 11,
  parameter int ROOT_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       operand,
  input  logic [ROOT_W-1:0] root_in,
  output logic [31:0]       in,
  output logic [32:0]       factor,
  output logic [3:0]        iter,
  output logic              clear,
  output logic              busy,
  output logic              done,
  output logic [ROOT_W-1:0] root
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;
  state_t state, state_n;
  logic [3:0] iter_n;
  logic [32:0] y;
  // next state, next iteration index, datapath controls and trial factor
  always_comb begin
    state_n = state;
    iter_n = 4'd0;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        iter_n = 4'(ITERS - 1);
      end
      LOAD: begin
        state_n = RUN;
        iter_n = 4'(ITERS - 1);
      end
      RUN: begin
        state_n = iter == 4'd0 ? CAPTURE : RUN;
        iter_n = iter == 4'd0 ? 4'd0 : iter - 4'd1;
      end
      default: state_n = IDLE;
    endcase
    clear = state == IDLE || state == LOAD;
    busy = state != IDLE;
    y = {{(33 - ROOT_W){1'b0}}, root_in};
    factor = clear ? 33'd1 : 33'd12 * y * y + 33'd6 * y + 33'd1;
  end
  // state, operand latch, iteration counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in <= 32'd0;
      iter <= 4'd0;
      done <= 1'b0;
      root <= '0;
    end else begin
      state <= state_n;
      iter <= iter_n;
      done <= state == CAPTURE;
      if (state == IDLE && start) in <= operand;
      if (state == CAPTURE) root <= root_in;
    end
  end
endmodule

// File: tb/tb_cube_root_ctrl.sv
// tb_cube_root_ctrl: scoreboard bench with a behavioural cube-root datapath model
module tb_cube_root_ctrl;
  logic clk = 0, reset, start;
  logic [31:0] operand, in;
  logic [10:0] root_in, root, y, force_val;
  logic [32:0] factor, rem, x33, t;
  logic [3:0] iter;
  logic clear, busy, done, force_en;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [10:0] r; int c;} exp_t;
  exp_t q[$];

  cube_root_ctrl dut (.clk(clk), .reset(reset), .start(start), .operand(operand),
    .root_in(root_in), .in(in), .factor(factor), .iter(iter), .clear(clear),
    .busy(busy), .done(done), .root(root));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // restoring radix-2 cube-root datapath: 3 radicand bits per step, MSB group first
  assign x33 = {1'b0, in};
  assign root_in = force_en ? force_val : y;
  always @(posedge clk) begin
    if (clear) begin
      rem <= 33'd0;
      y <= 11'd0;
    end else begin
      t = {rem[29:0], x33[3*iter +: 3]};
      if (t >= factor) begin
        rem <= t - factor;
        y <= {y[9:0], 1'b1};
      end else begin
        rem <= t;
        y <= {y[9:0], 1'b0};
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("root", root, e.r);
        chk("latency", cyc - e.c, 13);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic go(input logic [31:0] op, input logic [10:0] r);
    exp_t e;
    @(negedge clk);
    start = 1;
    operand = op;
    e.r = r;
    e.c = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    exp_t e;
    int n;
    reset = 1; start = 0; operand = 0; force_en = 0; force_val = 0;
    repeat (2) @(negedge clk);
    chk("rst_in", in, 0);
    chk("rst_iter", iter, 0);
    chk("rst_clear", clear, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_root", root, 0);
    chk("rst_factor", factor, 1);
    reset = 0;
    go(27, 3);
    chk("load_clear", clear, 1);
    chk("load_busy", busy, 1);
    chk("load_iter", iter, 10);
    chk("load_in", in, 27);
    for (int k = 10; k >= 0; k--) begin
      @(negedge clk);
      chk("run_iter", iter, 64'(k));
      chk("run_clear", clear, 0);
      chk("run_busy", busy, 1);
    end
    @(negedge clk);
    chk("cap_iter", iter, 0);
    chk("cap_busy", busy, 1);
    chk("cap_done", done, 0);
    @(negedge clk);
    chk("done_27", done, 1);
    go(0, 0); wait_done();
    go(1000, 10); wait_done();
    go(999, 9); wait_done();
    go(32'hFFFFFFFF, 1625); wait_done();
    go(1000, 10);
    repeat (2) @(negedge clk);
    start = 1; operand = 5;
    @(negedge clk);
    start = 0;
    chk("ignore_in_a", in, 1000);
    repeat (3) @(negedge clk);
    start = 1; operand = 123456;
    @(negedge clk);
    start = 0;
    chk("ignore_in_b", in, 1000);
    wait_done();
    @(negedge clk);
    start = 1; operand = 999;
    e.r = 9; e.c = cyc + 1; q.push_back(e);
    @(negedge clk);
    operand = 32'hFFFFFFFF;
    wait_done();
    e.r = 1625; e.c = cyc + 1; q.push_back(e);
    @(negedge clk);
    start = 0;
    chk("b2b_busy", busy, 1);
    wait_done();
    @(negedge clk);
    force_en = 1; force_val = 5;
    #1 chk("factor_clear", factor, 1);
    start = 1; operand = 8;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #1 chk("factor_5", factor, 331);
    force_val = 0;
    #1 chk("factor_0", factor, 1);
    force_val = 2047;
    #1 chk("factor_max", factor, 50294791);
    chk("factor_hi_zero", factor[32:26], 0);
    force_en = 0;
    n = 0;
    while (iter != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_iter5", iter, 5);
    reset = 1;
    @(negedge clk);
    chk("abort_clear", clear, 1);
    chk("abort_busy", busy, 0);
    chk("abort_iter", iter, 0);
    chk("abort_done", done, 0);
    reset = 0;
    repeat (16) @(negedge clk);
    go(64, 4); wait_done();
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
